// File: rtl/rotary_level_if.sv
// Encoder pins and level outputs of one colour channel.
//   enc_a, enc_b   raw quadrature pins, asynchronous to clk
//   level          current brightness level, feeds the PWM stage
//   level_changed  one-cycle pulse when level takes a new value
//   dir            direction of the last applied step (1 = up)
// master: encoder/testbench side. slave: rotary_level.
interface rotary_level_if #(
    parameter int unsigned WIDTH = 8
);
    logic             enc_a;
    logic             enc_b;
    logic [WIDTH-1:0] level;
    logic             level_changed;
    logic             dir;

    modport master (
        output enc_a,
        output enc_b,
        input  level,
        input  level_changed,
        input  dir
    );

    modport slave (
        input  enc_a,
        input  enc_b,
        output level,
        output level_changed,
        output dir
    );
endinterface

// File: rtl/rotary_level.sv
// Quadrature rotary-encoder front end producing the brightness level of one
// PWM colour channel. Synchronises and debounces the raw A/B pins, decodes one
// step per detent on each debounced rise of A, and keeps the level register.
// Ports:
//   clk    system clock
//   reset  synchronous, active-high reset
//   bus    rotary_level_if.slave: enc_a/enc_b in; level/level_changed/dir out
// Build option:
//   ROTARY_LEVEL_SATURATE_EN  defined: level clamps at 0 and 2^WIDTH-1
//                             undefined: level wraps modulo 2^WIDTH
module rotary_level #(
    parameter int unsigned WIDTH           = 8,
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned STEP            = 1,
    parameter int unsigned RESET_LEVEL     = 0
) (
    input  logic            clk,
    input  logic            reset,
    rotary_level_if.slave   bus
);
    localparam int unsigned      CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]    CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [WIDTH-1:0] STEP_W   = WIDTH'(STEP);
    localparam logic [WIDTH-1:0] RST_W    = WIDTH'(RESET_LEVEL);
`ifdef ROTARY_LEVEL_SATURATE_EN
    localparam logic [WIDTH-1:0] LVL_MAX  = '1;
`endif

    // Two-flop synchronisers, free running with no reset
    logic       r_a_meta, r_a_s, r_b_meta, r_b_s;
    logic [1:0] w_s;

    always_ff @(posedge clk) begin
        r_a_meta <= bus.enc_a;
        r_a_s    <= r_a_meta;
        r_b_meta <= bus.enc_b;
        r_b_s    <= r_b_meta;
    end

    assign w_s = {r_b_s, r_a_s};

    // Debounce per channel (index 0 = A, 1 = B) plus delayed copy for edges.
    // Reset loads the synchronised value so a resting A=1 gives no edge.
    logic [1:0]    r_stable, r_stable_d;
    logic [CW-1:0] r_cnt [2];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stable   <= w_s;
            r_stable_d <= w_s;
            for (int i = 0; i < 2; i++) r_cnt[i] <= '0;
        end else begin
            r_stable_d <= r_stable;
            for (int i = 0; i < 2; i++) begin
                if (w_s[i] == r_stable[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == CNT_LAST) begin
                    r_stable[i] <= w_s[i];
                    r_cnt[i]    <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + CW'(1);
                end
            end
        end
    end

    // x1 decode: step on debounced A rise unless B moved in the same cycle
    logic w_rise, w_b_chg, w_step, w_up;

    assign w_rise  = r_stable[0] & ~r_stable_d[0];
    assign w_b_chg = r_stable[1] ^ r_stable_d[1];
    assign w_step  = w_rise & ~w_b_chg;
    assign w_up    = ~r_stable[1];

    // Next level value
    logic [WIDTH-1:0] w_level_nxt;
    logic [WIDTH-1:0] r_level;
    logic             r_changed;
    logic             r_dir;

    always_comb begin
        w_level_nxt = r_level;
        if (w_step) begin
            if (w_up) begin
`ifdef ROTARY_LEVEL_SATURATE_EN
                w_level_nxt = (r_level > (LVL_MAX - STEP_W)) ? LVL_MAX : r_level + STEP_W;
`else
                w_level_nxt = r_level + STEP_W;
`endif
            end else begin
`ifdef ROTARY_LEVEL_SATURATE_EN
                w_level_nxt = (r_level < STEP_W) ? '0 : r_level - STEP_W;
`else
                w_level_nxt = r_level - STEP_W;
`endif
            end
        end
    end

    // Output registers; a clamped step at a bound still records direction
    always_ff @(posedge clk) begin
        if (reset) begin
            r_level   <= RST_W;
            r_changed <= 1'b0;
            r_dir     <= 1'b1;
        end else begin
            r_level   <= w_level_nxt;
            r_changed <= (w_level_nxt != r_level);
            if (w_step) r_dir <= w_up;
        end
    end

    assign bus.level         = r_level;
    assign bus.level_changed = r_changed;
    assign bus.dir           = r_dir;
endmodule

// File: tb/tb_rotary_level.sv
// Randomised scoreboard bench for rotary_level. The driver pushes the expected
// level/pulse/dir with the cycle it is due; the monitor pops and compares.
module tb_rotary_level;
    localparam int unsigned DB   = 4;
    localparam int unsigned STP  = 1;
    localparam int unsigned RSTL = 0;
    localparam int          SET  = DB + 6;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    rotary_level_if #(.WIDTH(8)) ifc ();

    rotary_level #(
        .WIDTH(8), .DEBOUNCE_CYCLES(DB), .STEP(STP), .RESET_LEVEL(RSTL)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc)
    );

    typedef struct {
        int       due;
        bit       pulse;
        int       lvl;
        bit       dir;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   errors = 0;
    int   checks = 0;
    int   m_level;
    bit   m_dir;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void push(input int due, input bit pulse, input int lvl, input bit dir);
        exp_t e;
        e.due = due; e.pulse = pulse; e.lvl = lvl; e.dir = dir;
        sb.push_back(e);
    endfunction

    // Reference: integer arithmetic on the detent count
    function automatic int model_step(input int lvl, input bit up);
        int n;
        n = up ? lvl + int'(STP) : lvl - int'(STP);
`ifdef ROTARY_LEVEL_SATURATE_EN
        if (n > 255) n = 255;
        if (n < 0) n = 0;
`else
        n = ((n % 256) + 256) % 256;
`endif
        return n;
    endfunction

    // Monitor
    int cur_lvl;
    bit cur_dir;
    bit armed = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            chk("pulse", int'(ifc.level_changed), int'(e.pulse));
            chk("level", int'(ifc.level), e.lvl);
            chk("dir", int'(ifc.dir), int'(e.dir));
            cur_lvl = e.lvl;
            cur_dir = e.dir;
            armed   = 1'b1;
        end else if (sb.size() > 0 && sb[0].due < cyc) begin
            e = sb.pop_front();
            chk("overdue_entry", cyc, e.due);
        end else if (armed) begin
            chk("spurious_pulse", int'(ifc.level_changed), 0);
            chk("level_hold", int'(ifc.level), cur_lvl);
            chk("dir_hold", int'(ifc.dir), int'(cur_dir));
        end
    end

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One clean detent: B set for the direction, A rise held, then released
    task automatic detent(input bit up);
        int n;
        if (ifc.enc_b != !up) begin
            ifc.enc_b = !up;
            wait_n(SET);
        end
        ifc.enc_a = 1'b1;
        n = model_step(m_level, up);
        push(cyc + DB + 3, n != m_level, n, up);
        m_level = n;
        m_dir   = up;
        wait_n(SET);
        ifc.enc_a = 1'b0;
        wait_n(SET);
    endtask

    task automatic glitch_a();
        ifc.enc_a = 1'b1;
        wait_n($urandom_range(1, DB - 1));
        ifc.enc_a = 1'b0;
        wait_n(SET);
    endtask

    task automatic ambiguous();
        ifc.enc_a = 1'b1;
        ifc.enc_b = ~ifc.enc_b;
        wait_n(SET);
        ifc.enc_a = 1'b0;
        wait_n(SET);
    endtask

    task automatic toggle_b();
        ifc.enc_b = ~ifc.enc_b;
        wait_n(SET);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        push(cyc + 1, 1'b0, RSTL, 1'b1);
        m_level = RSTL;
        m_dir   = 1'b1;
        wait_n(2);
        reset = 1'b0;
        wait_n(SET);
    endtask

    initial begin
        reset     = 1'b1;
        ifc.enc_a = 1'b1;
        ifc.enc_b = 1'b0;
        @(negedge clk);
        push(cyc + 1, 1'b0, RSTL, 1'b1);
        m_level = RSTL;
        m_dir   = 1'b1;
        wait_n(4);
        reset = 1'b0;
        wait_n(100);
        push(cyc + 1, 1'b0, m_level, m_dir);
        wait_n(1);
        ifc.enc_a = 1'b0;
        wait_n(SET);

        // Directed: up, down, down across zero, up back across the bound
        detent(1'b1);
        detent(1'b0);
        detent(1'b0);
        detent(1'b1);

        // Short glitches never step; a clean detent afterwards does
        repeat (5) glitch_a();
        detent(1'b1);

        ambiguous();
        ambiguous();

        // Random mix
        repeat (40) begin
            case ($urandom_range(0, 4))
                0: detent(1'b1);
                1: detent(1'b0);
                2: glitch_a();
                3: ambiguous();
                default: toggle_b();
            endcase
        end

        // Reset two cycles before a pending debounce completes, from level 9
        do_reset();
        repeat (9) detent(1'b1);
        ifc.enc_b = 1'b0;
        ifc.enc_a = 1'b1;
        wait_n(DB - 1);
        reset = 1'b1;
        push(cyc + 1, 1'b0, RSTL, 1'b1);
        m_level = RSTL;
        m_dir   = 1'b1;
        wait_n(2);
        reset = 1'b0;
        wait_n(50);
        ifc.enc_a = 1'b0;
        wait_n(SET);

        // Final step after all of the above still lands correctly
        detent(1'b0);
        wait_n(SET);

        chk("scoreboard_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
